edit_ctrl: RTL and testbench

Front-end sequencer between the four raw push-buttons and the clock core's control inputs. It synchronises and debounces b1..b4, turns presses into mutually exclusive single-cycle pause/shift/inc/dec pulses, and auto-repeats inc/dec while a button is held. It also auto-resumes the clock after an idle timeout in edit mode. It replaces the bare falling-edge detectors in the top level and drives `pause_pulse`, `shift_pulse`, `inc_pulse` and `dec_pulse` of the clock core directly.

---
 rtl/edit_ctrl.sv | 173 +++++++++++++++++
 tb/tb_edit_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/edit_ctrl.sv
// Button front-end: sync + debounce b1..b4, one-hot pause/shift/inc/dec pulses, inc/dec auto-repeat, idle auto-resume.
// Latency: pulse registered 1 cycle after a debounced fall (2 sync + DEBOUNCE_MS ticks + 1 cycle from raw edge).
// Backpressure: none; presses losing priority in a cycle are dropped, never queued.
module edit_ctrl #(
    parameter int SYS_FREQ        = 24000000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int IDLE_TIMEOUT_S  = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic b4,
    input  logic paused,
    output logic pause_pulse,
    output logic shift_pulse,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic rep_active,
    output logic timeout_evt
);
    localparam int TICK_DIV = SYS_FREQ / 1000;
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW   = $clog2(DEBOUNCE_MS + 1);
    localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int SW   = $clog2(IDLE_TIMEOUT_S + 2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    raw, sync1, sync2, deb, deb_d, press;
    logic [DW-1:0] dcnt [4];
    logic          acc_pause, acc_shift, acc_inc, acc_dec, any_acc;
    logic [1:0]    state, state_nx;
    logic          key, key_nx, key_deb;
    logic [RW-1:0] rcnt, rcnt_nx;
    logic          rep_fire;
    logic [9:0]    ms_cnt;
    logic [SW-1:0] sec_cnt;
    logic          idle_en, to_fire;
    logic          p_pause, p_shift, p_inc, p_dec, p_evt, any_fire;

    assign raw  = {b4, b3, b2, b1};
    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Debounce: deb follows sync2 only after DEBOUNCE_MS consecutive ticks of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            for (int i = 0; i < 4; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (tick) begin
                    if (dcnt[i] == DW'(DEBOUNCE_MS - 1)) begin
                        deb[i]  <= sync2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + DW'(1);
                    end
                end
            end
        end
    end

    assign press     = deb_d & ~deb;
    assign acc_pause = press[0];
    assign acc_shift = !press[0] && press[1] && paused;
    assign acc_inc   = !press[0] && !press[1] && press[2] && paused;
    assign acc_dec   = !press[0] && !press[1] && !press[2] && press[3] && paused;
    assign any_acc   = acc_pause || acc_shift || acc_inc || acc_dec;
    assign key_deb   = key ? deb[3] : deb[2];

    always_comb begin
        state_nx = state;
        key_nx   = key;
        rcnt_nx  = rcnt;
        rep_fire = 1'b0;
        if (acc_inc || acc_dec) begin
            state_nx = S_DELAY;
            key_nx   = acc_dec;
            rcnt_nx  = '0;
        end else if (state != S_IDLE) begin
            if (key_deb || !paused || acc_pause || acc_shift) begin
                state_nx = S_IDLE;
                rcnt_nx  = '0;
            end else if (tick) begin
                if ((state == S_DELAY  && rcnt == RW'(REPEAT_DELAY_MS - 1)) ||
                    (state == S_REPEAT && rcnt == RW'(REPEAT_RATE_MS - 1))) begin
                    rep_fire = 1'b1;
                    state_nx = S_REPEAT;
                    rcnt_nx  = '0;
                end else begin
                    rcnt_nx = rcnt + RW'(1);
                end
            end
        end
    end

    assign idle_en = paused && (state == S_IDLE);
    assign to_fire = (IDLE_TIMEOUT_S != 0) && idle_en && tick &&
                     (ms_cnt == 10'd999) && (sec_cnt == SW'(IDLE_TIMEOUT_S - 1));

    // A press always beats the timeout; rep_fire never coexists with a press by construction.
    assign p_evt    = to_fire && !any_acc;
    assign p_pause  = acc_pause || p_evt;
    assign p_shift  = acc_shift;
    assign p_inc    = acc_inc || (rep_fire && !key);
    assign p_dec    = acc_dec || (rep_fire && key);
    assign any_fire = p_pause || p_shift || p_inc || p_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            key         <= 1'b0;
            rcnt        <= '0;
            ms_cnt      <= '0;
            sec_cnt     <= '0;
            pause_pulse <= 1'b0;
            shift_pulse <= 1'b0;
            inc_pulse   <= 1'b0;
            dec_pulse   <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nx;
            key         <= key_nx;
            rcnt        <= rcnt_nx;
            pause_pulse <= p_pause;
            shift_pulse <= p_shift;
            inc_pulse   <= p_inc;
            dec_pulse   <= p_dec;
            timeout_evt <= p_evt;
            if (!idle_en || any_fire) begin
                ms_cnt  <= '0;
                sec_cnt <= '0;
            end else if (tick && IDLE_TIMEOUT_S != 0) begin
                if (ms_cnt == 10'd999) begin
                    ms_cnt  <= '0;
                    sec_cnt <= sec_cnt + SW'(1);
                end else begin
                    ms_cnt <= ms_cnt + 10'd1;
                end
            end
        end
    end

    assign rep_active = (state != S_IDLE);

endmodule

// File: tb/tb_edit_ctrl.sv
// Directed bench for edit_ctrl at 4 cycles/ms; stimulus is aligned to the ms tick so pulse cycles are exact.
module tb_edit_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic b1 = 1'b1, b2 = 1'b1, b3 = 1'b1, b4 = 1'b1;
    logic paused = 1'b0;
    logic pause_pulse, shift_pulse, inc_pulse, dec_pulse, rep_active, timeout_evt;

    edit_ctrl #(
        .SYS_FREQ(4000), .DEBOUNCE_MS(2), .REPEAT_DELAY_MS(5),
        .REPEAT_RATE_MS(2), .IDLE_TIMEOUT_S(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .paused(paused), .pause_pulse(pause_pulse), .shift_pulse(shift_pulse),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .rep_active(rep_active),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; the DUT ms tick lands on every edge with cyc%4==0.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [3:0] b;      // {b1,b2,b3,b4}, 0 = pressed
        logic       p;
        int         n;
        int         ep, es, ei, ed;
        logic       er;
    } vec_t;

    int n_vec = 0, n_bad = 0;
    int cnt_p, cnt_s, cnt_i, cnt_d, cnt_t, n_multi, last_s;
    int q_d[$];
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        cnt_p = 0; cnt_s = 0; cnt_i = 0; cnt_d = 0; cnt_t = 0; last_s = -1;
        q_d.delete();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (pause_pulse) cnt_p++;
            if (shift_pulse) begin cnt_s++; last_s = cyc; end
            if (inc_pulse)   cnt_i++;
            if (dec_pulse)   begin cnt_d++; q_d.push_back(cyc); end
            if (timeout_evt) cnt_t++;
            if (int'(pause_pulse) + int'(shift_pulse) + int'(inc_pulse) + int'(dec_pulse) > 1)
                n_multi++;
        end
    endtask

    task automatic align();
        while (cyc % 4 != 0) run(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[16];
    int   e0;

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 16, 0, 0, 0, 0, 1'b0};
        tbl[1]  = '{4'b1101, 1'b0, 20, 0, 0, 0, 0, 1'b0};  // b3 ignored while running
        tbl[2]  = '{4'b1111, 1'b0, 20, 0, 0, 0, 0, 1'b0};
        tbl[3]  = '{4'b1101, 1'b1, 12, 0, 0, 1, 0, 1'b1};  // b3 in edit mode
        tbl[4]  = '{4'b1111, 1'b1, 12, 0, 0, 0, 0, 1'b0};  // release ends DELAY
        tbl[5]  = '{4'b0101, 1'b1, 12, 1, 0, 0, 0, 1'b0};  // b1+b3 together: b1 wins
        tbl[6]  = '{4'b1111, 1'b1, 12, 0, 0, 0, 0, 1'b0};
        tbl[7]  = '{4'b1011, 1'b1, 12, 0, 1, 0, 0, 1'b0};
        tbl[8]  = '{4'b1010, 1'b1, 12, 0, 0, 0, 1, 1'b1};
        tbl[9]  = '{4'b1010, 1'b0, 12, 0, 0, 0, 0, 1'b0};  // unpause aborts repeat
        tbl[10] = '{4'b1111, 1'b0, 12, 0, 0, 0, 0, 1'b0};
        tbl[11] = '{4'b1110, 1'b1, 12, 0, 0, 0, 1, 1'b1};
        tbl[12] = '{4'b1100, 1'b1, 12, 0, 0, 1, 0, 1'b1};  // retarget to inc
        tbl[13] = '{4'b1101, 1'b1, 12, 0, 0, 0, 0, 1'b1};  // old key release irrelevant
        tbl[14] = '{4'b1101, 1'b1,  8, 0, 0, 1, 0, 1'b1};  // first repeat of inc
        tbl[15] = '{4'b1111, 1'b1, 12, 0, 0, 1, 0, 1'b0};  // one more repeat, then idle
        n_multi = 0;

        #2 rst_n = 1'b0;
        #1 check("reset_outs", int'({pause_pulse, shift_pulse, inc_pulse, dec_pulse,
                                     rep_active, timeout_evt}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            {b1, b2, b3, b4} = tbl[i].b;
            paused = tbl[i].p;
            clr();
            run(tbl[i].n);
            check($sformatf("v%0d_pause", i), cnt_p, tbl[i].ep);
            check($sformatf("v%0d_shift", i), cnt_s, tbl[i].es);
            check($sformatf("v%0d_inc", i),   cnt_i, tbl[i].ei);
            check($sformatf("v%0d_dec", i),   cnt_d, tbl[i].ed);
            check($sformatf("v%0d_rep", i),   int'(rep_active), int'(tbl[i].er));
        end

        // Bounce on b1: no pulse while toggling every 3 cycles, one pulse once stable.
        paused = 1'b0;
        align();
        clr();
        for (int i = 0; i < 40; i++) begin
            b1 = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            run(1);
        end
        check("bounce_quiet", cnt_p, 0);
        b1 = 1'b0;
        run(20);
        check("bounce_press", cnt_p, 1);
        b1 = 1'b1;
        run(20);
        check("bounce_release", cnt_p, 1);

        // Auto-repeat: hold b4 for 160 cycles (40 ms).
        paused = 1'b1;
        align();
        clr();
        e0 = cyc;
        b4 = 1'b0;
        run(160);
        b4 = 1'b1;
        run(8);
        check("rep_held", int'(rep_active), 1);
        run(1);
        check("rep_fell", int'(rep_active), 0);
        run(39);
        exp_q.delete();
        exp_q.push_back(e0 + 9);
        for (int t = e0 + 28; t < e0 + 169; t += 8) exp_q.push_back(t);
        check("rep_count", q_d.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < q_d.size(); k++)
            check($sformatf("rep_at%0d", k), q_d[k] - e0, exp_q[k] - e0);

        // Idle timeout from reset with paused held.
        paused = 1'b1;
        do_reset();
        clr();
        run(3999);
        check("to_early", cnt_p, 0);
        run(1);
        check("to_pause", int'(pause_pulse), 1);
        check("to_evt", int'(timeout_evt), 1);
        run(1);
        check("to_one_cycle", int'({pause_pulse, timeout_evt}), 0);
        check("to_evt_count", cnt_t, 1);

        // b2 press just before the timeout suppresses it and restarts the count.
        do_reset();
        clr();
        run(3988);
        b2 = 1'b0;
        run(12);
        check("sup_shift", cnt_s, 1);
        check("sup_shift_cyc", last_s, 3997);
        check("sup_no_pause", cnt_p, 0);
        check("sup_no_evt", cnt_t, 0);
        run(3995);
        check("sup_restart_early", cnt_p, 0);
        run(1);
        check("sup_restart_fire", int'({pause_pulse, timeout_evt}), 3);
        b2 = 1'b1;
        run(20);

        // Reset during REPEAT, with b4 held through reset release.
        align();
        clr();
        b4 = 1'b0;
        run(36);
        check("rst_pre_dec", int'(dec_pulse), 1);
        check("rst_pre_rep", int'(rep_active), 1);
        rst_n = 1'b0;
        #1 check("rst_async", int'({pause_pulse, shift_pulse, inc_pulse, dec_pulse,
                                    rep_active, timeout_evt}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        run(20);
        check("rst_held_dec", cnt_d, 1);
        check("rst_held_cyc", (q_d.size() > 0) ? q_d[0] : -1, 9);
        b4 = 1'b1;
        run(20);

        check("one_hot", n_multi, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
